// File: rtl/mac_neuron.sv
// Sequential MAC neuron: bias preload, then N_INPUTS (x, w) beats into a saturating 21-bit accumulator.
// Latency: out_valid rises the cycle after the N_INPUTS-th accepted beat (start-to-result >= N_INPUTS+1).
// Backpressure: in_ready only in ACC; the result is held stable in DONE until out_ready.
module mac_neuron #(
  parameter int N_INPUTS = 16,
  parameter int ACC_W    = 21
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [15:0]      bias,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       x,
  input  logic [7:0]       w,
  output logic [ACC_W-1:0] acc_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             sat_flag
);

  // Counter sized for the largest legal N_INPUTS (1023).
  localparam int CNT_W = 10;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_INPUTS - 1);
  localparam logic [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic signed [16:0] x_ext;
  logic signed [16:0] w_ext;
  logic signed [16:0] product;
  logic [ACC_W:0]     sum;
  logic [ACC_W-1:0]   acc_sat;
  logic               beat;
  logic               sat_hi;
  logic               sat_lo;

  // x is unsigned, w is signed; both widened to 17 bits so the product fits exactly.
  assign x_ext   = {9'b0, x};
  assign w_ext   = {{9{w[7]}}, w};
  assign product = x_ext * w_ext;

  // One guard bit above the accumulator: disagreeing top two bits mean overflow.
  assign sum    = {acc_out[ACC_W-1], acc_out} + {{(ACC_W-16){product[16]}}, product};
  assign sat_hi = ~sum[ACC_W] &  sum[ACC_W-1];
  assign sat_lo =  sum[ACC_W] & ~sum[ACC_W-1];
  assign beat   = in_valid & in_ready;

  // Clamp the widened sum back into the accumulator range.
  always_comb begin
    acc_sat = sum[ACC_W-1:0];
    if (sat_hi) begin
      acc_sat = ACC_MAX;
    end else if (sat_lo) begin
      acc_sat = ACC_MIN;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; in_ready, out_valid and busy decode the state directly.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = ACC;
        end
      end
      ACC: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid && (cnt == LAST_CNT)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Accumulator, beat counter and sticky saturation flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_out  <= '0;
      cnt      <= '0;
      sat_flag <= 1'b0;
    end else if ((state == IDLE) && start) begin
      acc_out  <= {{(ACC_W-16){bias[15]}}, bias};
      cnt      <= '0;
      sat_flag <= 1'b0;
    end else if (beat) begin
      acc_out <= acc_sat;
      cnt     <= cnt + CNT_W'(1);
      if (sat_hi || sat_lo) begin
        sat_flag <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mac_neuron.sv
// Bench for mac_neuron: three instances (N_INPUTS = 4, 40, 1) against an integer reference model.
// Directed operations pin known results and latencies; a randomized phase follows.
// Inputs change 1 time unit after the rising edge; outputs are checked on the falling edge.
module tb_mac_neuron;
  localparam int ACC_W = 21;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             start_s    [3];
  logic [15:0]      bias_s     [3];
  logic             in_valid_s [3];
  logic             in_ready_s [3];
  logic [7:0]       x_s        [3];
  logic [7:0]       w_s        [3];
  logic [ACC_W-1:0] acc_s      [3];
  logic             out_valid_s[3];
  logic             out_ready_s[3];
  logic             busy_s     [3];
  logic             sat_s      [3];

  mac_neuron #(.N_INPUTS(4), .ACC_W(ACC_W)) u_n4 (
    .clk(clk), .rst(rst), .start(start_s[0]), .bias(bias_s[0]),
    .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]), .x(x_s[0]), .w(w_s[0]),
    .acc_out(acc_s[0]), .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]),
    .busy(busy_s[0]), .sat_flag(sat_s[0]));

  mac_neuron #(.N_INPUTS(40), .ACC_W(ACC_W)) u_n40 (
    .clk(clk), .rst(rst), .start(start_s[1]), .bias(bias_s[1]),
    .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]), .x(x_s[1]), .w(w_s[1]),
    .acc_out(acc_s[1]), .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]),
    .busy(busy_s[1]), .sat_flag(sat_s[1]));

  mac_neuron #(.N_INPUTS(1), .ACC_W(ACC_W)) u_n1 (
    .clk(clk), .rst(rst), .start(start_s[2]), .bias(bias_s[2]),
    .in_valid(in_valid_s[2]), .in_ready(in_ready_s[2]), .x(x_s[2]), .w(w_s[2]),
    .acc_out(acc_s[2]), .out_valid(out_valid_s[2]), .out_ready(out_ready_s[2]),
    .busy(busy_s[2]), .sat_flag(sat_s[2]));

  int tests = 0;
  int fails = 0;

  // Reference model: mode 0 = waiting for start, 1 = taking beats, 2 = holding result.
  int nn    [3] = '{4, 40, 1};
  int m_mode[3] = '{0, 0, 0};
  int m_acc [3] = '{0, 0, 0};
  int m_cnt [3] = '{0, 0, 0};
  bit m_sat [3] = '{0, 0, 0};
  int m_sum;

  logic [7:0] tx[64];
  logic [7:0] tw[64];

  task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model update from the inputs present at the rising edge.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_mode[k] = 0;
        m_acc[k]  = 0;
        m_cnt[k]  = 0;
        m_sat[k]  = 0;
      end else if (m_mode[k] == 0) begin
        if (start_s[k]) begin
          m_mode[k] = 1;
          m_acc[k]  = int'($signed(bias_s[k]));
          m_cnt[k]  = 0;
          m_sat[k]  = 0;
        end
      end else if (m_mode[k] == 1) begin
        if (in_valid_s[k]) begin
          m_sum = m_acc[k] + int'(x_s[k]) * int'($signed(w_s[k]));
          if (m_sum > 1048575) begin
            m_sum    = 1048575;
            m_sat[k] = 1;
          end else if (m_sum < -1048576) begin
            m_sum    = -1048576;
            m_sat[k] = 1;
          end
          m_acc[k] = m_sum;
          m_cnt[k] = m_cnt[k] + 1;
          if (m_cnt[k] == nn[k]) m_mode[k] = 2;
        end
      end else begin
        if (out_ready_s[k]) m_mode[k] = 0;
      end
    end
  end

  // Per-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("in_ready[%0d]", k),  in_ready_s[k],  m_mode[k] == 1);
      chk($sformatf("out_valid[%0d]", k), out_valid_s[k], m_mode[k] == 2);
      chk($sformatf("busy[%0d]", k),      busy_s[k],      m_mode[k] != 0);
      chk($sformatf("sat_flag[%0d]", k),  sat_s[k],       m_sat[k]);
      if (m_mode[k] == 2) chk($sformatf("acc_out[%0d]", k), $signed(acc_s[k]), m_acc[k]);
    end
  end

  // Start an operation, feed n beats from tx/tw (optional gap before beat gap_at),
  // and return at the falling edge of the first out_valid cycle; lat counts the start cycle as 1.
  task automatic run_op(input int k, input int b, input int n, input int gap_at,
                        input int gap_len, output int lat);
    bit seen;
    step();
    bias_s[k]  = 16'(b);
    start_s[k] = 1'b1;
    lat = 1;
    step();
    start_s[k] = 1'b0;
    lat++;
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          in_valid_s[k] = 1'b0;
          step();
          lat++;
        end
      end
      in_valid_s[k] = 1'b1;
      x_s[k] = tx[i];
      w_s[k] = tw[i];
      step();
      lat++;
    end
    in_valid_s[k] = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 8 && !seen; t++) begin
      @(negedge clk);
      if (out_valid_s[k]) seen = 1'b1;
      else begin
        step();
        lat++;
      end
    end
    chk($sformatf("op_done_in_time[%0d]", k), seen, 1);
  endtask

  task automatic finish_op(input int k);
    step();
    out_ready_s[k] = 1'b1;
    step();
    out_ready_s[k] = 1'b0;
  endtask

  initial begin
    int lat;
    int ph;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      start_s[k] = 1'b0; bias_s[k] = '0; in_valid_s[k] = 1'b0;
      x_s[k] = '0; w_s[k] = '0; out_ready_s[k] = 1'b0;
    end
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) chk($sformatf("reset_acc[%0d]", k), acc_s[k], 0);

    // Plain accumulation, back-to-back beats.
    for (int i = 0; i < 4; i++) begin
      tx[i] = 8'(10 * (i + 1));
      tw[i] = 8'(i + 1);
    end
    run_op(0, 0, 4, -1, 0, lat);
    chk("t1_latency", lat, 6);
    chk("t1_acc", $signed(acc_s[0]), 300);
    chk("t1_sat", sat_s[0], 0);
    chk("t1_model", m_acc[0], 300);

    // Hold the result while start and in_valid are pulsed in DONE.
    for (int i = 0; i < 5; i++) begin
      step();
      start_s[0]    = 1'b1;
      in_valid_s[0] = 1'(i % 2);
      @(negedge clk);
      chk("t4_out_valid", out_valid_s[0], 1);
      chk("t4_in_ready", in_ready_s[0], 0);
      chk("t4_acc_stable", $signed(acc_s[0]), 300);
    end
    step();
    out_ready_s[0] = 1'b1;
    step();
    out_ready_s[0] = 1'b0;
    start_s[0]     = 1'b0;
    in_valid_s[0]  = 1'b0;
    @(negedge clk);
    chk("t4_out_valid_drop", out_valid_s[0], 0);
    chk("t4_idle_busy", busy_s[0], 0);
    step();
    @(negedge clk);
    chk("t4_start_ignored", busy_s[0], 0);

    // Negative bias and weights, with a two-cycle stall between beats 2 and 3.
    for (int i = 0; i < 4; i++) begin
      tx[i] = 8'd10;
      tw[i] = 8'hFB;
    end
    run_op(0, -500, 4, 2, 2, lat);
    chk("t2_latency", lat, 8);
    chk("t2_acc", $signed(acc_s[0]), -700);
    chk("t2_raw", acc_s[0], 21'h1FFD44);
    chk("t2_sat", sat_s[0], 0);
    finish_op(0);

    // Positive and negative saturation over 40 beats.
    for (int i = 0; i < 40; i++) begin
      tx[i] = 8'd255;
      tw[i] = 8'h7F;
    end
    run_op(1, 32767, 40, -1, 0, lat);
    chk("t3_latency", lat, 42);
    chk("t3_pos_acc", $signed(acc_s[1]), 1048575);
    chk("t3_pos_sat", sat_s[1], 1);
    finish_op(1);
    for (int i = 0; i < 40; i++) tw[i] = 8'h80;
    run_op(1, -32768, 40, -1, 0, lat);
    chk("t3_neg_acc", $signed(acc_s[1]), -1048576);
    chk("t3_neg_raw", acc_s[1], 21'h100000);
    chk("t3_neg_sat", sat_s[1], 1);
    finish_op(1);

    // Reset in the middle of an operation, then a fresh one.
    step();
    bias_s[0]  = 16'd3;
    start_s[0] = 1'b1;
    step();
    start_s[0]    = 1'b0;
    in_valid_s[0] = 1'b1;
    x_s[0] = 8'd1;
    w_s[0] = 8'd1;
    step();
    step();
    in_valid_s[0] = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_rst_in_ready", in_ready_s[0], 0);
    chk("t5_rst_out_valid", out_valid_s[0], 0);
    chk("t5_rst_busy", busy_s[0], 0);
    chk("t5_rst_sat", sat_s[0], 0);
    chk("t5_rst_acc", acc_s[0], 0);
    for (int i = 0; i < 4; i++) begin
      tx[i] = 8'd1;
      tw[i] = 8'd1;
    end
    run_op(0, 7, 4, -1, 0, lat);
    chk("t5_acc", $signed(acc_s[0]), 11);
    finish_op(0);

    // Single-beat operation.
    tx[0] = 8'd255;
    tw[0] = 8'h80;
    run_op(2, 100, 1, -1, 0, lat);
    chk("t6_latency", lat, 3);
    chk("t6_acc", $signed(acc_s[2]), -32540);
    chk("t6_sat", sat_s[2], 0);
    finish_op(2);

    // Randomized traffic on all instances; phases bias the data towards saturation.
    for (int c = 0; c < 3000; c++) begin
      step();
      rst = ($urandom_range(0, 499) == 0);
      ph  = (c / 300) % 3;
      for (int k = 0; k < 3; k++) begin
        start_s[k]     = ($urandom_range(0, 3) == 0);
        in_valid_s[k]  = ($urandom_range(0, 9) < 7);
        out_ready_s[k] = 1'($urandom_range(0, 1));
        bias_s[k]      = 16'($urandom);
        if (ph == 0) begin
          x_s[k] = 8'd255;
          w_s[k] = 8'h7F;
        end else if (ph == 1) begin
          x_s[k] = 8'd255;
          w_s[k] = 8'h80;
        end else begin
          x_s[k] = 8'($urandom);
          w_s[k] = 8'($urandom);
        end
      end
    end
    step();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      start_s[k] = 1'b0;
      in_valid_s[k] = 1'b0;
      out_ready_s[k] = 1'b1;
    end
    repeat (5) step();
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
